comparador_limiar: RTL
======================

Name: comparador_limiar

Overview:
- Sequential successor to the constant equality comparator.
- Compares a streamed WIDTH-bit sample against run-time programmable reference registers. Four modes: EQ, GT, LT, WINDOW.
- Debounces the match with a confirm/release state machine and counts confirmed match events.
- Sits after a sampled data source (ADC, counter, sensor bus) and drives flags and interrupts to control logic.

Parameters:
- WIDTH, 4: sample and reference width in bits.
- CONST, 10: reset value of ref_hi, and therefore the reset-time EQ target.
- DEB, 3: number of consecutive valid samples needed to assert or release result. Legal range is 1..255.
- CNT_W, 8: width of hit_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample qualifier.
- in  in  WIDTH  sample value.
- mode  in  2  compare mode: 00 EQ, 01 GT, 10 LT, 11 WINDOW.
- ref_we  in  1  reference write strobe.
- ref_sel  in  1  write target: 0 selects ref_hi, 1 selects ref_lo.
- ref_data  in  WIDTH  reference write data.
- cnt_clr  in  1  clear hit_count.
- raw  out  1  registered undebounced compare of the last valid sample.
- result  out  1  debounced match flag.
- rise  out  1  one-cycle pulse when result goes 0 to 1.
- hit_count  out  CNT_W  saturating count of rise events.

Behaviour:
- Reset values (synchronous rst=1, any cycle including mid-streak): ref_hi=CONST, ref_lo=0, raw=0, result=0, rise=0, hit_count=0, state=IDLE, streak counter=0.
- Combinational match, unsigned by default:
  - EQ: in==ref_hi.
  - GT: in>ref_hi.
  - LT: in<ref_hi.
  - WINDOW: ref_lo<=in<=ref_hi. If ref_lo>ref_hi, WINDOW never matches.
- raw: updated at each clock edge where in_valid=1. Holds its value otherwise.
- Cycles with in_valid=0 are ignored entirely: no state, streak or output change, and the streak is not broken.
- FSM states: IDLE, CONFIRM, MATCH, RELEASE. All transitions occur only on valid cycles; the streak counter is internal.
  - IDLE: a match moves to CONFIRM with streak=1. If DEB=1, go directly to MATCH instead.
  - CONFIRM: a match increments streak; on reaching DEB, go to MATCH. A miss returns to IDLE with streak=0.
  - MATCH: a miss moves to RELEASE with streak=1. If DEB=1, go directly to IDLE instead.
  - RELEASE: a miss increments streak; on reaching DEB, go to IDLE. A match returns to MATCH.
- result=1 in MATCH and RELEASE. It is registered with the state, so result rises at the same edge that samples the DEB-th consecutive matching valid sample.
- rise=1 for exactly the cycle following entry into MATCH from CONFIRM or IDLE. Re-entry from RELEASE does not pulse.
- hit_count: +1 on each rise, saturating at 2^CNT_W-1. With cnt_clr=1 the next value is 0, except when cnt_clr and the increment coincide, in which case the next value is 1.
- Reference writes: ref_we=1 writes ref_data to the register chosen by ref_sel at the edge. The new value is used by the compare from the following cycle. A write does not reset the FSM or the streak.
- mode is sampled on every valid cycle. A mode change does not reset the streak; the debounce absorbs the change.
- Simultaneous ref_we and in_valid in the same cycle: the compare uses the old reference.

Optional Feature:
- Macro COMPARADOR_SIGNED_EN.
- Defined: in, ref_hi and ref_lo are two's complement, and GT, LT and WINDOW compare signed. The CONST reset value is interpreted signed.
- Undefined: all compares are unsigned.
- EQ is identical in both builds.

Decomposition:
- Package comparador_pkg holds:
  - mode encoding constants (MODE_EQ, MODE_GT, MODE_LT, MODE_WIN);
  - FSM state encoding (ST_IDLE, ST_CONFIRM, ST_MATCH, ST_RELEASE);
  - the helper function for the saturating increment.
- One sub-module, comparador_deb: the DEB-parametrised confirm/release FSM with its streak counter. It takes match and valid and outputs result and rise.
- The top level holds the reference registers, the compare logic, raw and hit_count.

Test Plan:
- Reset defaults: after reset, drive in=10 valid for 3 cycles in EQ mode -> raw=1 after the 1st edge, result=1 after the 3rd edge, one rise pulse, hit_count=1.
- Debounce break: EQ, DEB=3, valid samples 10,10,7,10,10,10 -> result stays 0 through the 5th sample and rises after the 6th; hit_count=1.
- Gaps ignored: 10, idle, 10, idle, 10 -> result=1 after the third valid sample. Then 3 valid samples of 0 -> result=0. A single 0 between 10s during MATCH does not drop result.
- WINDOW plus reference write: write ref_lo=3 and ref_hi=8, mode=11, samples 5,5,5 -> result=1. Then write ref_lo=9 (inverted window), 3 samples of 5 -> result=0.
- Counter edges: CNT_W=2, force 4 match/release episodes -> hit_count stops at 3. cnt_clr in the same cycle as a rise -> hit_count=1.
- Signed build (COMPARADOR_SIGNED_EN, WIDTH=4): GT mode, ref_hi=0, in=4'b1111 for 3 cycles -> result=0. The unsigned build with the same stimulus -> result=1.

Source files
------------

// File: rtl/comparador_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comparador_pkg
// Description : Shared encodings and helpers for the comparador_limiar
//               threshold comparator (compare modes, debounce FSM states,
//               saturating increment).
// Revision    : 1.0 - initial release
// ============================================================================
package comparador_pkg;

  // Compare mode encoding, as seen on the mode input
  localparam logic [1:0] MODE_EQ  = 2'b00;
  localparam logic [1:0] MODE_GT  = 2'b01;
  localparam logic [1:0] MODE_LT  = 2'b10;
  localparam logic [1:0] MODE_WIN = 2'b11;

  // Confirm/release debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_MATCH   = 2'd2,
    ST_RELEASE = 2'd3
  } deb_state_t;

  // Increment that sticks at maxv instead of wrapping; callers cast to their width
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comparador_deb.sv
`default_nettype none
// ============================================================================
// Module      : comparador_deb
// Description : Confirm/release debounce FSM. result asserts after DEB
//               consecutive matching valid samples and releases after DEB
//               consecutive missing ones; invalid cycles are transparent.
//               rise pulses once per fresh entry into MATCH.
// Revision    : 1.0 - initial release
// ============================================================================
module comparador_deb
  import comparador_pkg::*;
#(
  parameter int DEB = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic match,
  output logic result,
  output logic rise
);

  // DEB is limited to 1..255, so an 8-bit streak never overflows
  localparam logic [7:0] c_deb = 8'(DEB);

  deb_state_t r_state;
  deb_state_t w_state_nxt;
  logic [7:0] r_streak;
  logic [7:0] w_streak_nxt;
  logic [7:0] w_streak_inc;
  logic       w_enter;
  logic       r_result;
  logic       r_rise;

  assign w_streak_inc = r_streak + 8'd1;

  // State, streak and registered flags; invalid cycles leave everything except rise alone
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_streak <= 8'd0;
      r_result <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      r_result <= (w_state_nxt == ST_MATCH) || (w_state_nxt == ST_RELEASE);
      r_rise   <= w_enter;
    end
  end

  // Next-state logic; w_enter flags a fresh (non-RELEASE) entry into MATCH
  always_comb begin
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    w_enter      = 1'b0;
    if (valid) begin
      case (r_state)
        ST_IDLE: begin
          if (match) begin
            if (c_deb == 8'd1) begin
              w_state_nxt  = ST_MATCH;
              w_streak_nxt = 8'd0;
              w_enter      = 1'b1;
            end else begin
              w_state_nxt  = ST_CONFIRM;
              w_streak_nxt = 8'd1;
            end
          end
        end
        ST_CONFIRM: begin
          if (match) begin
            if (w_streak_inc >= c_deb) begin
              w_state_nxt  = ST_MATCH;
              w_streak_nxt = 8'd0;
              w_enter      = 1'b1;
            end else begin
              w_streak_nxt = w_streak_inc;
            end
          end else begin
            w_state_nxt  = ST_IDLE;
            w_streak_nxt = 8'd0;
          end
        end
        ST_MATCH: begin
          if (!match) begin
            if (c_deb == 8'd1) begin
              w_state_nxt  = ST_IDLE;
              w_streak_nxt = 8'd0;
            end else begin
              w_state_nxt  = ST_RELEASE;
              w_streak_nxt = 8'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (match) begin
            w_state_nxt  = ST_MATCH;
            w_streak_nxt = 8'd0;
          end else if (w_streak_inc >= c_deb) begin
            w_state_nxt  = ST_IDLE;
            w_streak_nxt = 8'd0;
          end else begin
            w_streak_nxt = w_streak_inc;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_streak_nxt = 8'd0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign rise   = r_rise;

endmodule
`default_nettype wire

// File: rtl/comparador_limiar.sv
`default_nettype none
// ============================================================================
// Module      : comparador_limiar
// Description : Streaming threshold comparator with programmable references
//               (EQ/GT/LT/WINDOW), debounced match flag, rise pulse and a
//               saturating hit counter.
//               Build option: COMPARADOR_SIGNED_EN makes GT/LT/WINDOW treat
//               samples and references as two's complement.
// Revision    : 1.0 - initial release
// ============================================================================
module comparador_limiar
  import comparador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CONST = 10,
  parameter int DEB   = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic             ref_we,
  input  logic             ref_sel,
  input  logic [WIDTH-1:0] ref_data,
  input  logic             cnt_clr,
  output logic             raw,
  output logic             result,
  output logic             rise,
  output logic [CNT_W-1:0] hit_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  logic [WIDTH-1:0] r_ref_hi;
  logic [WIDTH-1:0] r_ref_lo;
  logic             r_raw;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] w_hit_inc;
  logic             w_gt_hi;
  logic             w_lt_hi;
  logic             w_ge_lo;
  logic             w_match;
  logic             w_result;
  logic             w_rise;

  // Reference registers; a write lands at the edge so a same-cycle sample sees the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_hi <= WIDTH'(CONST);
      r_ref_lo <= '0;
    end else if (ref_we) begin
      if (ref_sel) r_ref_lo <= ref_data;
      else         r_ref_hi <= ref_data;
    end
  end

`ifdef COMPARADOR_SIGNED_EN
  assign w_gt_hi = $signed(in) >  $signed(r_ref_hi);
  assign w_lt_hi = $signed(in) <  $signed(r_ref_hi);
  assign w_ge_lo = $signed(in) >= $signed(r_ref_lo);
`else
  assign w_gt_hi = in >  r_ref_hi;
  assign w_lt_hi = in <  r_ref_hi;
  assign w_ge_lo = in >= r_ref_lo;
`endif

  // Mode select; an inverted window (lo > hi) can never satisfy both bounds
  always_comb begin
    w_match = 1'b0;
    case (mode)
      MODE_EQ:  w_match = (in == r_ref_hi);
      MODE_GT:  w_match = w_gt_hi;
      MODE_LT:  w_match = w_lt_hi;
      MODE_WIN: w_match = w_ge_lo && !w_gt_hi;
      default:  w_match = 1'b0;
    endcase
  end

  // Undebounced compare of the most recent valid sample
  always_ff @(posedge clk) begin
    if (rst)           r_raw <= 1'b0;
    else if (in_valid) r_raw <= w_match;
  end

  comparador_deb #(
    .DEB (DEB)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .valid  (in_valid),
    .match  (w_match),
    .result (w_result),
    .rise   (w_rise)
  );

  assign w_hit_inc = CNT_W'(sat_inc(32'(r_hit_count), 32'(c_cnt_max)));

  // Hit counter follows the rise pulse; a clear that coincides with a rise keeps that hit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count <= '0;
    end else if (cnt_clr) begin
      r_hit_count <= w_rise ? CNT_W'(1) : '0;
    end else if (w_rise) begin
      r_hit_count <= w_hit_inc;
    end
  end

  assign raw       = r_raw;
  assign result    = w_result;
  assign rise      = w_rise;
  assign hit_count = r_hit_count;

endmodule
`default_nettype wire
